// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the fifo write-arbiter / read-sequencer.
// Optional sticky error output is enabled with FIFO_CTRL_ERR_EN.
package fifo_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_DEPTH = 16;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_ctrl_rr_arbiter.sv
// Round-robin arbiter: first unmasked request at or after the pointer wins.
// Pointer advances past the winner only when a grant is issued.
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   lo_idx, hi_idx, win;
    logic [NREQ-1:0] elig;
    logic            hi_hit;

    always_comb begin
        elig   = req_i & ~mask_i;
        lo_idx = '0;
        hi_idx = '0;
        hi_hit = 1'b0;
        // Descending scan leaves the lowest matching index in each slot.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (elig[j]) begin
                lo_idx = PW'(j);
                if (PW'(j) >= ptr_q) begin
                    hi_idx = PW'(j);
                    hi_hit = 1'b1;
                end
            end
        end
        win   = hi_hit ? hi_idx : lo_idx;
        gnt_o = '0;
        ptr_d = ptr_q;
        if (en_i && (|elig)) begin
            gnt_o = NREQ'(1) << win;
            ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Shares a fifo write port among NREQ requesters and sequences its reads.
// Define FIFO_CTRL_ERR_EN to add the sticky err output.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  inp_clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_d,
    output logic [NREQ-1:0]       gnt,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  write_flg,
    output logic [WIDTH-1:0]      inp_d,
    output logic                  read_flg,
    output logic                  rd_vld,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      level,
    output logic                  flush_done
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(DEPTH);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, arb_gnt;
    logic              wflg_q, rflg_q, rvld_q;
    logic [WIDTH-1:0]  inp_d_q, inp_d_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic              full_q, empty_q;
    logic              fdone_q, fdone_d;
    logic              wr_allow, wr_go, rd_go;

    assign wr_allow = (state_q == RUN) && (level_q != LVL_MAX);

    // Last cycle's winner is masked so its stale request is not re-taken.
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i  (inp_clk),
        .rst_ni (reset),
        .en_i   (wr_allow),
        .req_i  (req),
        .mask_i (gnt_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        fdone_d = 1'b0;
        wr_go   = |arb_gnt;
        rd_go   = (level_q != '0) && ((state_q == DRAIN) || pop);
        inp_d_d = inp_d_q;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                inp_d_d = req_d[i*WIDTH +: WIDTH];
            end
        end
        level_d = level_q + CNT_W'(wr_go) - CNT_W'(rd_go);
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Wait for the final read_flg cycle to retire first.
                if (level_q == '0 && !rflg_q) begin
                    state_d = RUN;
                    fdone_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge inp_clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            gnt_q   <= '0;
            wflg_q  <= 1'b0;
            inp_d_q <= '0;
            rflg_q  <= 1'b0;
            rvld_q  <= 1'b0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= arb_gnt;
            wflg_q  <= wr_go;
            inp_d_q <= inp_d_d;
            rflg_q  <= rd_go;
            rvld_q  <= rflg_q;
            level_q <= level_d;
            full_q  <= (level_d == LVL_MAX);
            empty_q <= (level_d == '0);
            fdone_q <= fdone_d;
        end
    end

    assign gnt        = gnt_q;
    assign write_flg  = wflg_q;
    assign inp_d      = inp_d_q;
    assign read_flg   = rflg_q;
    assign rd_vld     = rvld_q;
    assign level      = level_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign flush_done = fdone_q;

`ifdef FIFO_CTRL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == RUN && pop && level_q == '0) begin
            err_d = 1'b1;
        end
        if (state_q == DRAIN && flush) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge inp_clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
